// File: rtl/day10_machine_scheduler_pkg.sv
// Shared types and helpers for the day-10 machine scheduler.
package day10_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_START,
    ST_READ_WAIT,
    ST_SOLVE_START,
    ST_SOLVE_WAIT,
    ST_ACCUMULATE,
    ST_DONE
  } sched_state_t;

  function automatic int pressesWidth(input int maxButtons);
    return $clog2(maxButtons + 1);
  endfunction

  // Returns {carry, value}: value clamps to all-ones of 'width' bits (width <= 64).
  function automatic logic [64:0] satAdd(input logic [63:0] a, input logic [63:0] b,
                                         input int width);
    logic [64:0] sum;
    logic [63:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = 64'((65'd1 << width) - 65'd1);
    if (sum > {1'b0, limit}) begin
      return {1'b1, limit};
    end
    return sum;
  endfunction

endpackage

// File: rtl/day10_machine_scheduler_if.sv
// Handshake and status bundle between the scheduler and its environment.
interface day10_machine_scheduler_if #(
  parameter int PRESSES_W     = 5,
  parameter int TOTAL_W       = 32,
  parameter int MACHINE_CNT_W = 16
);
  logic                     start;
  logic                     reader_start;
  logic                     reader_ready;
  logic                     end_of_input;
  logic                     solver_start;
  logic                     solver_done;
  logic [PRESSES_W-1:0]     solver_presses;
  logic                     solver_unsolvable;
  logic                     busy;
  logic                     done;
  logic [TOTAL_W-1:0]       total_presses;
  logic [MACHINE_CNT_W-1:0] num_machines;
  logic                     error_unsolvable;
  logic                     error_overflow;

  modport master (
    output start, reader_ready, end_of_input, solver_done, solver_presses, solver_unsolvable,
    input  reader_start, solver_start, busy, done, total_presses, num_machines,
           error_unsolvable, error_overflow
  );

  modport slave (
    input  start, reader_ready, end_of_input, solver_done, solver_presses, solver_unsolvable,
    output reader_start, solver_start, busy, done, total_presses, num_machines,
           error_unsolvable, error_overflow
  );
endinterface

// File: rtl/day10_machine_scheduler_sat_accumulator.sv
// Saturating running total of per-machine press counts with sticky overflow flag.
module day10_sat_accumulator
  import day10_pkg::*;
#(
  parameter int PRESSES_W = 5,
  parameter int TOTAL_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_add,
  input  logic [PRESSES_W-1:0] i_addend,
  output logic [TOTAL_W-1:0]   o_total,
  output logic                 o_overflow
);
  logic [TOTAL_W-1:0] r_total;
  logic               r_overflow;
  logic [TOTAL_W-1:0] w_sum;
  logic               w_carry;

  assign w_sum   = TOTAL_W'(satAdd(64'(r_total), 64'(i_addend), TOTAL_W));
  assign w_carry = 1'(satAdd(64'(r_total), 64'(i_addend), TOTAL_W) >> 64);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_total    <= '0;
      r_overflow <= 1'b0;
    end else if (i_add) begin
      r_total <= w_sum;
      if (w_carry) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_total    = r_total;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/day10_machine_scheduler.sv
// Alternates reader and solver one machine at a time so they never share the input storage concurrently.
module day10_machine_scheduler
  import day10_pkg::*;
#(
  parameter int MAX_NUM_BUTTONS = 16,
  parameter int PRESSES_W       = pressesWidth(MAX_NUM_BUTTONS),
  parameter int TOTAL_W         = 32,
  parameter int MACHINE_CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  day10_machine_scheduler_if.slave bus
);
  sched_state_t             r_state, w_nextState;
  logic                     r_lastMachine;
  logic                     r_unsolvable;
  logic                     r_errUnsolvable;
  logic [PRESSES_W-1:0]     r_presses;
  logic [MACHINE_CNT_W-1:0] r_numMachines;
  logic                     w_clear, w_accumulate;
  logic                     w_readerStart, w_solverStart, w_busy, w_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Start pulses are suppressed while rst is high so nothing leaks out in the reset cycle.
  always_comb begin
    w_nextState   = r_state;
    w_readerStart = 1'b0;
    w_solverStart = 1'b0;
    w_busy        = 1'b1;
    w_done        = 1'b0;
    w_clear       = 1'b0;
    w_accumulate  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_busy = 1'b0;
        w_done = (r_state == ST_DONE);
        if (bus.start) begin
          w_clear     = 1'b1;
          w_nextState = ST_READ_START;
        end
      end
      ST_READ_START: begin
        w_readerStart = !rst;
        w_nextState   = ST_READ_WAIT;
      end
      ST_READ_WAIT:   if (bus.reader_ready) w_nextState = ST_SOLVE_START;
      ST_SOLVE_START: begin
        w_solverStart = !rst;
        w_nextState   = ST_SOLVE_WAIT;
      end
      ST_SOLVE_WAIT:  if (bus.solver_done) w_nextState = ST_ACCUMULATE;
      ST_ACCUMULATE: begin
        w_accumulate = 1'b1;
        w_nextState  = r_lastMachine ? ST_DONE : ST_READ_START;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastMachine   <= 1'b0;
      r_unsolvable    <= 1'b0;
      r_errUnsolvable <= 1'b0;
      r_presses       <= '0;
      r_numMachines   <= '0;
    end else begin
      if (w_clear) begin
        r_errUnsolvable <= 1'b0;
        r_numMachines   <= '0;
      end
      if (r_state == ST_READ_WAIT && bus.reader_ready) begin
        r_lastMachine <= bus.end_of_input;
      end
      if (r_state == ST_SOLVE_WAIT && bus.solver_done) begin
        r_presses    <= bus.solver_presses;
        r_unsolvable <= bus.solver_unsolvable;
      end
      if (w_accumulate) begin
        if (r_unsolvable) r_errUnsolvable <= 1'b1;
        if (r_numMachines != '1) r_numMachines <= r_numMachines + 1'b1;
      end
    end
  end

  day10_sat_accumulator #(
    .PRESSES_W (PRESSES_W),
    .TOTAL_W   (TOTAL_W)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_add      (w_accumulate && !r_unsolvable),
    .i_addend   (r_presses),
    .o_total    (bus.total_presses),
    .o_overflow (bus.error_overflow)
  );

  assign bus.reader_start     = w_readerStart;
  assign bus.solver_start     = w_solverStart;
  assign bus.busy             = w_busy;
  assign bus.done             = w_done;
  assign bus.num_machines     = r_numMachines;
  assign bus.error_unsolvable = r_errUnsolvable;
endmodule

// File: tb/tb_day10_machine_scheduler.sv
// Scoreboard bench: driver emulates reader/solver, monitor checks results and pulse timing against a reference model.
module tb_day10_machine_scheduler;
  localparam int MAX_NUM_BUTTONS = 16;
  localparam int PRESSES_W       = $clog2(MAX_NUM_BUTTONS + 1);
  localparam int TOTAL_W         = 8;
  localparam int MACHINE_CNT_W   = 4;
  localparam int TOTAL_MAX       = (1 << TOTAL_W) - 1;
  localparam int CNT_MAX         = (1 << MACHINE_CNT_W) - 1;

  typedef struct {
    int total;
    int num;
    bit errU;
    bit errO;
    int machines;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;
  exp_t expQ[$];
  int   runPresses[$];
  bit   runUnsolv[$];

  always #5 clk = ~clk;

  day10_machine_scheduler_if #(
    .PRESSES_W(PRESSES_W), .TOTAL_W(TOTAL_W), .MACHINE_CNT_W(MACHINE_CNT_W)
  ) bus ();

  day10_machine_scheduler #(
    .MAX_NUM_BUTTONS(MAX_NUM_BUTTONS), .TOTAL_W(TOTAL_W), .MACHINE_CNT_W(MACHINE_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: total is a clamped sum of solvable machines, count clamps at its maximum.
  function automatic exp_t modelRun(input int count);
    exp_t e;
    e.total    = 0;
    e.errU     = 0;
    e.errO     = 0;
    e.machines = count;
    e.num      = (count > CNT_MAX) ? CNT_MAX : count;
    for (int i = 0; i < count; i++) begin
      if (runUnsolv[i]) e.errU = 1;
      else if (e.total + runPresses[i] > TOTAL_MAX) begin
        e.total = TOTAL_MAX;
        e.errO  = 1;
      end else e.total += runPresses[i];
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    bus.start             = 1'b0;
    bus.reader_ready      = 1'b0;
    bus.solver_done       = 1'b0;
    bus.end_of_input      = 1'($urandom_range(0, 1));
    bus.solver_presses    = PRESSES_W'($urandom_range(0, 31));
    bus.solver_unsolvable = 1'($urandom_range(0, 1));
  endtask

  task automatic waitOutput(input int which, input int budget, input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((which == 0 && bus.reader_start) || (which == 1 && bus.solver_start) ||
          (which == 2 && bus.done)) begin
        ok = 1;
        break;
      end
    end
    checkOutput(name, longint'(ok), 1);
  endtask

  task automatic recoverFromHang();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expQ.delete();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
    checkOutput({tag, "_total"}, bus.total_presses, 0);
    checkOutput({tag, "_num"}, bus.num_machines, 0);
    checkOutput({tag, "_err_unsolvable"}, bus.error_unsolvable, 0);
    checkOutput({tag, "_err_overflow"}, bus.error_overflow, 0);
    checkOutput({tag, "_reader_start"}, bus.reader_start, 0);
    checkOutput({tag, "_solver_start"}, bus.solver_start, 0);
  endtask

  task automatic applyStimulus(input bit spurious, input int abortAt);
    exp_t e;
    bit   ok;
    int   n, d;
    n = runPresses.size();
    if (abortAt < 0) begin
      e = modelRun(n);
      expQ.push_back(e);
    end
    tick();
    bus.start = 1'b1;
    for (int i = 0; i < n; i++) begin
      waitOutput(0, 20, "wait_reader_start", ok);
      if (!ok) begin recoverFromHang(); return; end
      d = $urandom_range(1, 4);
      for (int k = 1; k < d; k++) begin
        tick();
        if (spurious && $urandom_range(0, 2) == 0) bus.solver_done = 1'b1;
        if (spurious && $urandom_range(0, 2) == 0) bus.start = 1'b1;
      end
      tick();
      bus.reader_ready = 1'b1;
      bus.end_of_input = (i == n - 1);
      if (spurious && $urandom_range(0, 3) == 0) bus.solver_done = 1'b1;
      waitOutput(1, 20, "wait_solver_start", ok);
      if (!ok) begin recoverFromHang(); return; end
      if (i == abortAt) begin
        tick();
        e = modelRun(i);
        checkOutput("pre_reset_total", bus.total_presses, e.total);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdleOutputs("after_reset");
        return;
      end
      d = $urandom_range(1, 4);
      for (int k = 1; k < d; k++) begin
        tick();
        if (spurious && $urandom_range(0, 2) == 0) begin
          bus.reader_ready = 1'b1;
          bus.end_of_input = 1'b1;
        end
        if (spurious && $urandom_range(0, 2) == 0) bus.start = 1'b1;
      end
      tick();
      bus.solver_done       = 1'b1;
      bus.solver_presses    = PRESSES_W'(runPresses[i]);
      bus.solver_unsolvable = runUnsolv[i];
      if (spurious && $urandom_range(0, 3) == 0) bus.reader_ready = 1'b1;
    end
    waitOutput(2, 10, "wait_done", ok);
    if (!ok) recoverFromHang();
  endtask

  // Monitor: inputs seen here belong to the cycle that just ended, outputs to the new one.
  initial begin
    int     nRS, nSS;
    longint cyc, tRR, tSD, tStart;
    bit     waitRead, waitSolve, prevDone, prevBusy;
    exp_t   e;
    nRS = 0; nSS = 0; cyc = 0; tRR = -100; tSD = -100; tStart = -100;
    waitRead = 0; waitSolve = 0; prevDone = 0; prevBusy = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        nRS = 0; nSS = 0; waitRead = 0; waitSolve = 0; prevDone = 0; prevBusy = 0;
      end else begin
        if (bus.start && !prevBusy) tStart = cyc - 1;
        if (waitRead && bus.reader_ready) begin tRR = cyc - 1; waitRead = 0; end
        if (waitSolve && bus.solver_done) begin tSD = cyc - 1; waitSolve = 0; end
        if (bus.reader_start || bus.solver_start)
          checkOutput("no_overlap", bus.reader_start & bus.solver_start, 0);
        if (bus.reader_start) begin
          nRS++;
          waitRead = 1;
          checkOutput("busy_when_reading", bus.busy, 1);
          if (nRS == 1) checkOutput("start_to_reader_start", cyc - tStart, 1);
          else          checkOutput("solver_done_to_reader_start", cyc - tSD, 2);
        end
        if (bus.solver_start) begin
          nSS++;
          waitSolve = 1;
          checkOutput("reader_ready_to_solver_start", cyc - tRR, 1);
        end
        if (bus.done && !prevDone) begin
          if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_done: got done=1, expected no completion pending");
          end else begin
            e = expQ.pop_front();
            checkOutput("total_presses", bus.total_presses, e.total);
            checkOutput("num_machines", bus.num_machines, e.num);
            checkOutput("error_unsolvable", bus.error_unsolvable, e.errU);
            checkOutput("error_overflow", bus.error_overflow, e.errO);
            checkOutput("reader_start_count", nRS, e.machines);
            checkOutput("solver_start_count", nSS, e.machines);
            checkOutput("solver_done_to_done", cyc - tSD, 2);
            checkOutput("busy_in_done", bus.busy, 0);
          end
          nRS = 0;
          nSS = 0;
        end
        prevDone = bus.done;
        prevBusy = bus.busy;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checkIdleOutputs("reset");

    runPresses = {2, 5, 3};          runUnsolv = {1'b0, 1'b0, 1'b0};
    applyStimulus(0, -1);
    runPresses = {4};                runUnsolv = {1'b0};
    applyStimulus(0, -1);
    runPresses = {1, 7, 2};          runUnsolv = {1'b0, 1'b1, 1'b0};
    applyStimulus(0, -1);

    runPresses.delete(); runUnsolv.delete();
    for (int i = 0; i < 17; i++) begin runPresses.push_back(15); runUnsolv.push_back(1'b0); end
    applyStimulus(0, -1);
    runPresses.delete(); runUnsolv.delete();
    for (int i = 0; i < 17; i++) begin runPresses.push_back(16); runUnsolv.push_back(1'b0); end
    applyStimulus(1, -1);

    runPresses = {9, 6};             runUnsolv = {1'b0, 1'b0};
    applyStimulus(1, 1);
    runPresses = {6};                runUnsolv = {1'b0};
    applyStimulus(0, -1);

    for (int r = 0; r < 12; r++) begin
      runPresses.delete(); runUnsolv.delete();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        runPresses.push_back($urandom_range(0, MAX_NUM_BUTTONS));
        runUnsolv.push_back($urandom_range(0, 5) == 0);
      end
      applyStimulus(1, -1);
    end

    repeat (5) tick();
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
